// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the registered N:1 stream multiplexer.
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // A two-channel mux still needs one select bit, which $clog2(2)=1 gives but $clog2(1)=0 would not.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Valid/ready bundle between N input channels and one registered output.
interface stream_mux_rr_if
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2_safe(NUM_CH)
);
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [SEL_W-1:0]        select;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, select, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, select, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: searches from the channel after the last winner, wrapping around.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2_safe(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic [SEL_W-1:0] ptr_reg;
  int               idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = SEL_W'(idx);
      end
    end
  end

  // Pointer starts at the last channel so the first grant after reset favours ch0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= SEL_W'(NUM_CH - 1);
    end else if (advance) begin
      ptr_reg <= gnt_idx;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with explicit-select or round-robin grant and a registered output stage.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2_safe(NUM_CH),
  parameter int MODE   = MODE_SEL
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_rr_if.slave  bus
);

  logic              can_load;
  logic              gnt_valid;
  logic              xfer;
  logic [SEL_W-1:0]  gnt_idx;
  logic [WIDTH-1:0]  sel_data;
  logic [NUM_CH-1:0] in_ready_vec;

  logic [WIDTH-1:0]  out_data_reg;
  logic [SEL_W-1:0]  out_ch_reg;
  logic              out_valid_reg;

  assign can_load = !out_valid_reg || bus.out_ready;
  // rst_n gates the handshake so no channel sees ready while reset is held.
  assign xfer     = rst_n && can_load && gnt_valid;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [NUM_CH-1:0] rr_gnt;

      rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.in_valid),
        .advance (xfer),
        .gnt     (rr_gnt),
        .gnt_idx (gnt_idx)
      );
      assign gnt_valid = |rr_gnt;
    end else begin : g_sel
      // Out-of-range select values match no channel and therefore grant nothing.
      always_comb begin
        gnt_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          if (int'(bus.select) == c && bus.in_valid[c]) gnt_valid = 1'b1;
        end
      end
      assign gnt_idx = bus.select;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(gnt_idx) == c) sel_data = bus.in_data[c*WIDTH +: WIDTH];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign in_ready_vec[gi] = xfer && (int'(gnt_idx) == gi);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else if (xfer) begin
      out_data_reg  <= sel_data;
      out_ch_reg    <= gnt_idx;
      out_valid_reg <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_vec;
  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_valid = out_valid_reg;

endmodule
